// File: rtl/uart_io_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM encoding,
// register offsets and status-word bit positions.
package uart_io_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam logic [1:0] UART_DATA = 2'b00;
  localparam logic [1:0] UART_CTRL = 2'b10;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART serializer.
// A push while full is accepted only when a pop happens on the same edge.
module uart_tx_fifo
  import uart_io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{(CNT_W-1){1'b0}}, push_ok} - {{(CNT_W-1){1'b0}}, pop_ok};
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter: register decode, byte FIFO and serializer FSM.
// tx and tx_busy are registered and reset asynchronously so the line idles high at once.
module uart_tx_io
  import uart_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        uartcs,
  input  logic        uartwrite,
  input  logic        uartread,
  input  logic [1:0]  uartaddr,
  input  logic [15:0] uart_wdata,
  output logic [15:0] uart_rdata,
  output logic        tx,
  output logic        tx_busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic             wr_en, push, ovf_set, ovf_clr;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             baud_last;
  logic [15:0]      status;
  logic             unused_wdata;

  assign unused_wdata = ^uart_wdata[15:8];

  assign wr_en   = uartcs & uartwrite;
  assign push    = wr_en & (uartaddr == UART_DATA);
  assign ovf_clr = wr_en & (uartaddr == UART_CTRL) & uart_wdata[3];
  // A same-edge pop frees a slot, so only a push that really drops counts.
  assign ovf_set = push & fifo_full & ~fifo_pop;
  assign ovf_d   = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .rst_n(rst_n),
    .push (push),
    .pop  (fifo_pop),
    .wdata(uart_wdata[7:0]),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign baud_last = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          baud_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;

  always_comb begin
    status                             = '0;
    status[STAT_BUSY]                  = (state_q != StIdle);
    status[STAT_FULL]                  = fifo_full;
    status[STAT_EMPTY]                 = fifo_empty;
    status[STAT_OVF]                   = ovf_q;
    status[STAT_CNT_LSB +: CNT_W]      = fifo_count;
  end

  assign uart_rdata = (uartcs & uartread) ? status : 16'h0000;

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io with CLKS_PER_BIT=4, FIFO_DEPTH=4: a decode vector
// table plus hand-timed sequences for framing, overflow, reset and push/pop collisions.
module tb_uart_tx_io;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        uartcs = 1'b0;
  logic        uartwrite = 1'b0;
  logic        uartread = 1'b0;
  logic [1:0]  uartaddr = 2'b00;
  logic [15:0] uart_wdata = 16'h0000;
  logic [15:0] uart_rdata;
  logic        tx;
  logic        tx_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  uart_tx_io #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .uartcs    (uartcs),
    .uartwrite (uartwrite),
    .uartread  (uartread),
    .uartaddr  (uartaddr),
    .uart_wdata(uart_wdata),
    .uart_rdata(uart_rdata),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  typedef struct {
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic        rcs;
    logic        rd;
    logic [1:0]  raddr;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_bt;   // {tx_busy, tx}
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Called at a falling edge; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    uartcs = 1'b1; uartwrite = 1'b1; uartaddr = a; uart_wdata = d;
    @(negedge clock);
    uartcs = 1'b0; uartwrite = 1'b0; uartaddr = 2'b00; uart_wdata = 16'h0000;
  endtask

  task automatic rd_status(input string name, input logic [15:0] exp);
    logic [15:0] v;
    uartcs = 1'b1; uartread = 1'b1; uartaddr = 2'b00;
    #1;
    v = uart_rdata;
    uartcs = 1'b0; uartread = 1'b0;
    chk(name, v, exp);
  endtask

  task automatic check_frame(input string name, input logic [7:0] b);
    logic exp_tx;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      exp_tx = 1'b0;
      else if (i == 9) exp_tx = 1'b1;
      else             exp_tx = b[i-1];
      for (int c = 0; c < int'(CPB); c++) begin
        @(posedge clock);
        #1;
        chk($sformatf("%s bit%0d cyc%0d", name, i, c), {14'h0, tx_busy, tx}, {14'h0, 1'b1, exp_tx});
      end
    end
  endtask

  task automatic check_idle(input string name, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("%s cyc%0d", name, c), {14'h0, tx_busy, tx}, 16'h0001);
    end
  endtask

  task automatic do_reset();
    uartcs = 1'b0; uartwrite = 1'b0; uartread = 1'b0; uartaddr = 2'b00; uart_wdata = 16'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    vecs[0] = '{1'b1, 1'b1, 2'b01, 16'h00AA, 1'b1, 1'b1, 2'b00, 16'h0004, 2'b01};
    vecs[1] = '{1'b1, 1'b1, 2'b11, 16'h00BB, 1'b1, 1'b1, 2'b11, 16'h0004, 2'b01};
    vecs[2] = '{1'b0, 1'b1, 2'b00, 16'h00CC, 1'b1, 1'b1, 2'b01, 16'h0004, 2'b01};
    vecs[3] = '{1'b1, 1'b0, 2'b00, 16'h00DD, 1'b1, 1'b1, 2'b10, 16'h0004, 2'b01};
    vecs[4] = '{1'b1, 1'b1, 2'b10, 16'h0008, 1'b0, 1'b1, 2'b00, 16'h0000, 2'b01};
    vecs[5] = '{1'b0, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 2'b00, 16'h0000, 2'b01};
    vecs[6] = '{1'b1, 1'b1, 2'b00, 16'h0042, 1'b1, 1'b1, 2'b11, 16'h0005, 2'b10};

    // Single frame 0x55 from idle.
    do_reset();
    rd_status("reset status", 16'h0004);
    chk("reset line", {14'h0, tx_busy, tx}, 16'h0001);
    wr(2'b00, 16'h0055);
    chk("tx before start edge", {15'h0, tx}, 16'h0001);
    check_frame("frame55", 8'h55);
    check_idle("after55", 8);
    rd_status("status after 55", 16'h0004);

    // Back-to-back frames with no idle gap.
    do_reset();
    wr(2'b00, 16'h00A1);
    fork
      begin
        wr(2'b00, 16'h003C);
        repeat (4) @(negedge clock);
        rd_status("count during frameA1", 16'h0011);
      end
      check_frame("frameA1", 8'hA1);
    join
    check_frame("frame3C", 8'h3C);
    check_idle("after3C", 8);
    rd_status("status after 3C", 16'h0004);

    // Overflow: five pushes while busy with an empty FIFO, fifth dropped.
    do_reset();
    wr(2'b00, 16'h0011);
    repeat (2) @(negedge clock);
    wr(2'b00, 16'h0022);
    wr(2'b00, 16'h0033);
    wr(2'b00, 16'h0044);
    wr(2'b00, 16'h0055);
    wr(2'b00, 16'h0066);
    rd_status("overflow status", 16'h004B);
    wr(2'b10, 16'h0008);
    rd_status("overflow cleared", 16'h0043);
    repeat (32) @(negedge clock);
    check_frame("ovf frame22", 8'h22);
    check_frame("ovf frame33", 8'h33);
    check_frame("ovf frame44", 8'h44);
    check_frame("ovf frame55", 8'h55);
    check_idle("fifth byte dropped", 48);
    rd_status("status after ovf drain", 16'h0004);

    // Register decode table.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      uartcs = vecs[i].cs; uartwrite = vecs[i].we; uartaddr = vecs[i].addr;
      uart_wdata = vecs[i].wdata;
      @(negedge clock);
      uartcs = 1'b0; uartwrite = 1'b0; uartaddr = 2'b00; uart_wdata = 16'h0;
      @(negedge clock);
      uartcs = vecs[i].rcs; uartread = vecs[i].rd; uartaddr = vecs[i].raddr;
      #1;
      chk($sformatf("vec%0d rdata", i), uart_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d line", i), {14'h0, tx_busy, tx}, {14'h0, vecs[i].exp_bt});
      uartcs = 1'b0; uartread = 1'b0; uartaddr = 2'b00;
    end

    // Asynchronous reset during data bit 3 of 0xF0 (bit value 0).
    do_reset();
    wr(2'b00, 16'h00F0);
    repeat (18) @(negedge clock);
    chk("in data bit3", {14'h0, tx_busy, tx}, 16'h0002);
    rst_n = 1'b0;
    #1;
    chk("async reset line", {14'h0, tx_busy, tx}, 16'h0001);
    @(negedge clock);
    rst_n = 1'b1;
    rd_status("status after mid reset", 16'h0004);
    check_idle("no residual frame", 48);

    // Push on the same edge as the STOP-end pop with a full FIFO.
    do_reset();
    wr(2'b00, 16'h005A);
    wr(2'b00, 16'h00B0);
    wr(2'b00, 16'h00B1);
    wr(2'b00, 16'h00B2);
    wr(2'b00, 16'h00B3);
    rd_status("full before stop", 16'h0043);
    repeat (36) @(negedge clock);
    rd_status("full at stop end", 16'h0043);
    wr(2'b00, 16'h0099);
    rd_status("push+pop same edge", 16'h0043);
    repeat (119) @(negedge clock);
    check_frame("collide frameB3", 8'hB3);
    check_frame("collide frame99", 8'h99);
    check_idle("after collide", 8);
    rd_status("status after collide", 16'h0004);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
